// File: rtl/ysyx_22040759_mem_stage.sv
// MEM pipeline stage: latches the EXE payload, issues one data-memory request per
// load/store, waits for the response or write acknowledge, and forms the WB payload.
module ysyx_22040759_mem_stage (
    input  logic         clk,
    input  logic         rst,
    // EXE -> MEM
    input  logic         es_to_ms_valid,
    input  logic [172:0] es_to_ms_bus,
    input  logic [63:0]  es_alu_result,
    output logic         ms_allowin,
    // MEM -> WB
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [167:0] ms_to_ws_bus,
    // hazard / forwarding
    output logic [63:0]  ms_alu_result,
    output logic [4:0]   ms_rd,
    output logic         ms_reg_wen,
    output logic         ms_mem_ren,
    // data-memory request
    output logic         dreq_valid,
    input  logic         dreq_ready,
    output logic         dreq_wen,
    output logic [63:0]  dreq_addr,
    output logic [63:0]  dreq_wdata,
    output logic [7:0]   dreq_wstrb,
    output logic [1:0]   dreq_size,
    // data-memory response
    input  logic         drsp_valid,
    input  logic [63:0]  drsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_ms_valid;
    logic [172:0]   r_bus;
    logic [63:0]    r_alu;
    logic [63:0]    r_rdata;

    logic [31:0]    w_inst;
    logic [63:0]    w_src2;
    logic           w_mem_wen;
    logic           w_mem_ren;
    logic [2:0]     w_func3;
    logic [1:0]     w_wreg_sel;
    logic           w_reg_wen;
    logic [4:0]     w_rd;
    logic [63:0]    w_pc;

    logic           w_mem_op;
    logic           w_ready_go;
    logic [1:0]     w_size;
    logic [2:0]     w_off;
    logic [5:0]     w_shamt;
    logic [7:0]     w_strb_base;
    logic [63:0]    w_raw;
    logic [63:0]    w_load;
    logic [63:0]    w_result;

    // ------------------------------------------------------------------
    // Payload field decode
    // ------------------------------------------------------------------
    assign w_inst     = r_bus[172:141];
    assign w_src2     = r_bus[140:77];
    assign w_mem_wen  = r_bus[76];
    assign w_mem_ren  = r_bus[75];
    assign w_func3    = r_bus[74:72];
    assign w_wreg_sel = r_bus[71:70];
    assign w_reg_wen  = r_bus[69];
    assign w_rd       = r_bus[68:64];
    assign w_pc       = r_bus[63:0];

    assign w_mem_op   = w_mem_wen | w_mem_ren;
    assign w_size     = w_func3[1:0];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_ready_go     = !w_mem_op || (r_state == S_DONE);
    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            r_bus <= es_to_ms_bus;
            r_alu <= es_alu_result;
        end
    end

    // ------------------------------------------------------------------
    // Memory access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (r_ms_valid && w_mem_op) w_state_nxt = S_REQ;
            S_REQ:  if (dreq_ready)             w_state_nxt = S_WAIT;
            S_WAIT: if (drsp_valid)             w_state_nxt = S_DONE;
            S_DONE: if (ws_allowin)             w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_WAIT && drsp_valid) begin
            r_rdata <= drsp_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Request formation; sub-size offset bits are dropped so the lane
    // position is always naturally aligned to the access size.
    // ------------------------------------------------------------------
    always_comb begin
        w_off       = r_alu[2:0];
        w_strb_base = 8'h01;
        unique case (w_size)
            2'b00: begin
                w_off       = r_alu[2:0];
                w_strb_base = 8'h01;
            end
            2'b01: begin
                w_off       = {r_alu[2:1], 1'b0};
                w_strb_base = 8'h03;
            end
            2'b10: begin
                w_off       = {r_alu[2], 2'b00};
                w_strb_base = 8'h0F;
            end
            default: begin
                w_off       = 3'b000;
                w_strb_base = 8'hFF;
            end
        endcase
    end

    assign w_shamt    = {w_off, 3'b000};

    assign dreq_valid = (r_state == S_REQ);
    assign dreq_wen   = w_mem_wen;
    assign dreq_addr  = {r_alu[63:3], 3'b000};
    assign dreq_size  = w_size;
    assign dreq_wdata = w_src2 << w_shamt;
    assign dreq_wstrb = w_mem_wen ? (w_strb_base << w_off) : '0;

    // ------------------------------------------------------------------
    // Load extraction and result
    // ------------------------------------------------------------------
    assign w_raw = r_rdata >> w_shamt;

    always_comb begin
        w_load = '0;
        unique case (w_func3)
            3'b000:  w_load = {{56{w_raw[7]}},  w_raw[7:0]};
            3'b001:  w_load = {{48{w_raw[15]}}, w_raw[15:0]};
            3'b010:  w_load = {{32{w_raw[31]}}, w_raw[31:0]};
            3'b011:  w_load = w_raw;
            3'b100:  w_load = {56'd0, w_raw[7:0]};
            3'b101:  w_load = {48'd0, w_raw[15:0]};
            3'b110:  w_load = {32'd0, w_raw[31:0]};
            default: w_load = '0;
        endcase
    end

    assign w_result     = w_mem_ren ? w_load : r_alu;

    assign ms_to_ws_bus = {w_inst, w_wreg_sel, w_result, w_reg_wen, w_rd, w_pc};

    assign ms_alu_result = r_alu;
    assign ms_rd         = w_rd;
    assign ms_reg_wen    = w_reg_wen & r_ms_valid;
    assign ms_mem_ren    = w_mem_ren & r_ms_valid;

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Directed + randomized bench for the MEM stage; expectations come from a
// byte-lane reference model of the load/store rules.
module tb_ysyx_22040759_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         es_to_ms_valid;
    logic [172:0] es_to_ms_bus;
    logic [63:0]  es_alu_result;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [167:0] ms_to_ws_bus;
    logic [63:0]  ms_alu_result;
    logic [4:0]   ms_rd;
    logic         ms_reg_wen;
    logic         ms_mem_ren;
    logic         dreq_valid;
    logic         dreq_ready;
    logic         dreq_wen;
    logic [63:0]  dreq_addr;
    logic [63:0]  dreq_wdata;
    logic [7:0]   dreq_wstrb;
    logic [1:0]   dreq_size;
    logic         drsp_valid;
    logic [63:0]  drsp_rdata;

    int tests = 0;
    int fails = 0;

    ysyx_22040759_mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .es_alu_result  (es_alu_result),
        .ms_allowin     (ms_allowin),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_alu_result  (ms_alu_result),
        .ms_rd          (ms_rd),
        .ms_reg_wen     (ms_reg_wen),
        .ms_mem_ren     (ms_mem_ren),
        .dreq_valid     (dreq_valid),
        .dreq_ready     (dreq_ready),
        .dreq_wen       (dreq_wen),
        .dreq_addr      (dreq_addr),
        .dreq_wdata     (dreq_wdata),
        .dreq_wstrb     (dreq_wstrb),
        .dreq_size      (dreq_size),
        .drsp_valid     (drsp_valid),
        .drsp_rdata     (drsp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] inst;
        logic [63:0] src2;
        logic        wen;
        logic        ren;
        logic [2:0]  f3;
        logic [1:0]  wsel;
        logic        rwen;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] alu;
    } op_t;

    task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic int unsigned aligned_off(input logic [1:0] sz, input logic [2:0] off);
        int unsigned o;
        o = off;
        return o - (o % nbytes(sz));
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] mem, input logic [2:0] off);
        logic [63:0]  v;
        int unsigned  n;
        int unsigned  base;
        v    = '0;
        n    = nbytes(f3[1:0]);
        base = aligned_off(f3[1:0], off);
        if (f3 == 3'b111) return '0;
        for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = mem[8*(base+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1]) begin
            for (int unsigned i = 8*n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] ref_wstrb(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0]  s;
        int unsigned base;
        s    = '0;
        base = aligned_off(sz, off);
        for (int unsigned i = 0; i < 8; i++) s[i] = (i >= base) && (i < base + nbytes(sz));
        return s;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] src2, input logic [1:0] sz, input logic [2:0] off);
        logic [63:0] w;
        int unsigned base;
        w    = '0;
        base = aligned_off(sz, off);
        for (int unsigned i = base; i < 8; i++) w[8*i +: 8] = src2[8*(i-base) +: 8];
        return w;
    endfunction

    function automatic logic [172:0] to_bus(input op_t o);
        return {o.inst, o.src2, o.wen, o.ren, o.f3, o.wsel, o.rwen, o.rd, o.pc};
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.inst = $urandom;
        o.src2 = {$urandom, $urandom};
        o.wen  = 1'b0;
        o.ren  = 1'b0;
        o.f3   = 3'($urandom_range(0, 7));
        o.wsel = 2'($urandom_range(0, 3));
        o.rwen = 1'($urandom_range(0, 1));
        o.rd   = 5'($urandom_range(0, 31));
        o.pc   = {$urandom, $urandom};
        o.alu  = {$urandom, $urandom};
        return o;
    endfunction

    task automatic scramble();
        logic [191:0] g;
        g = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        es_to_ms_bus  = g[172:0];
        es_alu_result = {$urandom, $urandom};
    endtask

    // ---------------- transactions ----------------
    task automatic alu_txn(input op_t o);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = to_bus(o);
        es_alu_result  = o.alu;
        ws_allowin     = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        scramble();
        chk("alu_valid",   ms_to_ws_valid, 1'b1);
        chk("alu_bus",     ms_to_ws_bus, {o.inst, o.wsel, o.alu, o.rwen, o.rd, o.pc});
        chk("alu_no_dreq", dreq_valid, 1'b0);
        chk("alu_allowin", ms_allowin, 1'b1);
        chk("alu_reg_wen", ms_reg_wen, o.rwen);
        @(negedge clk);
        chk("alu_retired", ms_to_ws_valid, 1'b0);
    endtask

    task automatic mem_txn(input op_t o, input logic [63:0] rdata, input int ready_dly,
                           input int rsp_dly, input int ws_hold, input bit chain,
                           input bit use_want, input logic [63:0] want);
        logic [63:0]  res;
        logic [167:0] obus;
        logic [63:0]  e_addr;
        logic [63:0]  e_wdata;
        logic [7:0]   e_strb;
        int           cyc;
        res     = o.ren ? ref_load(o.f3, rdata, o.alu[2:0]) : o.alu;
        if (use_want) res = want;
        obus    = {o.inst, o.wsel, res, o.rwen, o.rd, o.pc};
        e_addr  = {o.alu[63:3], 3'b000};
        e_strb  = o.wen ? ref_wstrb(o.f3[1:0], o.alu[2:0]) : 8'h00;
        e_wdata = ref_wdata(o.src2, o.f3[1:0], o.alu[2:0]);

        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = to_bus(o);
        es_alu_result  = o.alu;
        ws_allowin     = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        scramble();
        chk("cap_dreq_idle", dreq_valid, 1'b0);
        chk("cap_allowin",   ms_allowin, 1'b0);
        chk("cap_out_valid", ms_to_ws_valid, 1'b0);
        chk("fwd_mem_ren",   ms_mem_ren, o.ren);
        chk("fwd_reg_wen",   ms_reg_wen, o.rwen);
        chk("fwd_rd",        ms_rd, o.rd);
        chk("fwd_alu",       ms_alu_result, o.alu);

        cyc = 0;
        while (dreq_valid !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_latency", cyc, 1);

        // request phase: hold ready low ready_dly cycles, spurious responses ignored
        for (int i = 0; i <= ready_dly; i++) begin
            chk("req_valid",   dreq_valid, 1'b1);
            chk("req_addr",    dreq_addr, e_addr);
            chk("req_wen",     dreq_wen, o.wen);
            chk("req_size",    dreq_size, o.f3[1:0]);
            chk("req_wstrb",   dreq_wstrb, e_strb);
            if (o.wen) chk("req_wdata", dreq_wdata, e_wdata);
            chk("req_allowin", ms_allowin, 1'b0);
            chk("req_out_valid", ms_to_ws_valid, 1'b0);
            drsp_valid = 1'($urandom_range(0, 1));
            drsp_rdata = {$urandom, $urandom};
            dreq_ready = (i == ready_dly);
            @(negedge clk);
        end
        dreq_ready = 1'b0;
        drsp_valid = 1'b0;
        chk("wait_no_req", dreq_valid, 1'b0);
        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            chk("wait_out_valid", ms_to_ws_valid, 1'b0);
            chk("wait_no_req2",   dreq_valid, 1'b0);
        end

        if (chain || ws_hold > 0) ws_allowin = 1'b0;
        drsp_valid = 1'b1;
        drsp_rdata = rdata;
        @(negedge clk);
        drsp_valid = 1'b0;
        drsp_rdata = {$urandom, $urandom};
        chk("done_valid",   ms_to_ws_valid, 1'b1);
        chk("done_bus",     ms_to_ws_bus, obus);
        chk("done_no_req",  dreq_valid, 1'b0);

        for (int i = 0; i < ws_hold; i++) begin
            @(negedge clk);
            chk("hold_valid",   ms_to_ws_valid, 1'b1);
            chk("hold_bus",     ms_to_ws_bus, obus);
            chk("hold_allowin", ms_allowin, 1'b0);
            chk("hold_no_req",  dreq_valid, 1'b0);
        end

        if (!chain) begin
            ws_allowin = 1'b1;
            #1;
            chk("done_allowin", ms_allowin, 1'b1);
            @(negedge clk);
            chk("retired_valid", ms_to_ws_valid, 1'b0);
            chk("retired_no_req", dreq_valid, 1'b0);
            chk("retired_allowin", ms_allowin, 1'b1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        op_t         o;
        logic [63:0] rd_data;
        int          cyc;
        int unsigned kind;

        rst            = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '0;
        es_alu_result  = '0;
        ws_allowin     = 1'b1;
        dreq_ready     = 1'b0;
        drsp_valid     = 1'b0;
        drsp_rdata     = '0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", ms_to_ws_valid, 1'b0);
        chk("rst_dreq",      dreq_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_allowin", ms_allowin, 1'b1);
        chk("post_rst_valid",   ms_to_ws_valid, 1'b0);

        // ALU pass-through
        o = rnd_op();
        o.pc  = 64'h0000_0000_8000_0000;
        o.alu = 64'h0000_0000_0000_1234;
        alu_txn(o);

        // LB / LBU of byte 3 = 0x80
        o = rnd_op();
        o.ren = 1'b1; o.f3 = 3'b000; o.alu = 64'h0000_0000_8000_1003;
        mem_txn(o, 64'h0000_0000_8000_0000, 0, 0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        o.f3 = 3'b100;
        mem_txn(o, 64'h0000_0000_8000_0000, 0, 1, 0, 1'b0, 1'b1, 64'h0000_0000_0000_0080);

        // SH to offset 6
        o = rnd_op();
        o.wen = 1'b1; o.f3 = 3'b001; o.src2 = 64'h0000_0000_0000_BEEF;
        o.alu = 64'h0000_0000_8000_2006;
        mem_txn(o, {$urandom, $urandom}, 0, 0, 0, 1'b0, 1'b0, '0);

        // backpressure on both request and writeback sides
        o = rnd_op();
        o.ren = 1'b1; o.f3 = 3'b010; o.alu = {$urandom, 29'($urandom), 3'b100};
        mem_txn(o, {$urandom, $urandom}, 3, 2, 2, 1'b0, 1'b0, '0);

        // LD and LW at offset 4
        o = rnd_op();
        o.ren = 1'b1; o.f3 = 3'b011; o.alu = 64'h0000_0000_8000_3000;
        mem_txn(o, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        o.f3 = 3'b010; o.alu = 64'h0000_0000_8000_3004;
        mem_txn(o, 64'hDEAD_BEEF_CAFE_F00D, 1, 0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF);

        // func3 = 111 loads yield zero
        o.f3 = 3'b111; o.alu = 64'h0000_0000_8000_3000;
        mem_txn(o, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 1'b0, 1'b1, 64'h0);

        // misaligned SW: low offset bit dropped
        o = rnd_op();
        o.wen = 1'b1; o.f3 = 3'b010; o.alu = 64'h0000_0000_8000_4005;
        mem_txn(o, {$urandom, $urandom}, 0, 0, 0, 1'b0, 1'b0, '0);

        // DONE->IDLE coincides with capture of the next mem op
        o = rnd_op();
        o.ren = 1'b1; o.f3 = 3'b001; o.alu = {$urandom, 29'($urandom), 3'b010};
        mem_txn(o, {$urandom, $urandom}, 0, 0, 1, 1'b1, 1'b0, '0);
        o = rnd_op();
        o.wen = 1'b1; o.f3 = 3'b011;
        mem_txn(o, {$urandom, $urandom}, 1, 1, 0, 1'b0, 1'b0, '0);

        // reset while waiting for the response
        o = rnd_op();
        o.ren = 1'b1; o.f3 = 3'b011; o.alu = {$urandom, 29'($urandom), 3'b000};
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = to_bus(o);
        es_alu_result  = o.alu;
        ws_allowin     = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        cyc = 0;
        while (dreq_valid !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstw_req_latency", cyc, 1);
        dreq_ready = 1'b1;
        @(negedge clk);
        dreq_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drsp_valid = 1'b1;
        drsp_rdata = {$urandom, $urandom};
        @(negedge clk);
        drsp_valid = 1'b0;
        chk("rstw_out_valid", ms_to_ws_valid, 1'b0);
        chk("rstw_dreq",      dreq_valid, 1'b0);
        chk("rstw_allowin",   ms_allowin, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("rstw_idle_valid", ms_to_ws_valid, 1'b0);
            chk("rstw_idle_dreq",  dreq_valid, 1'b0);
        end
        o = rnd_op();
        alu_txn(o);

        // randomized mix
        for (int n = 0; n < 30; n++) begin
            o    = rnd_op();
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                alu_txn(o);
            end else begin
                rd_data = {$urandom, $urandom};
                if (kind == 1) begin
                    o.ren = 1'b1;
                    o.alu[2:0] = 3'(aligned_off(o.f3[1:0], o.alu[2:0]));
                end else begin
                    o.wen = 1'b1;
                    o.f3  = {1'b0, o.f3[1:0]};
                end
                mem_txn(o, rd_data, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 2)), 1'b0, 1'b0, '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
